// File: rtl/pc_sequencer_if.sv
// Control/LUT/status bundle of the fetch-stage PC sequencer.
// The master side issues control requests and returns the LUT target.
interface pc_sequencer_if #(
    parameter int D     = 10,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          Start;
    logic          Stall;
    logic          Halt;
    logic          BranchEn;
    logic          RelMode;
    logic          CallEn;
    logic          RetEn;
    logic [3:0]    BranchIdx;
    logic [3:0]    LutAddr;
    logic [D-1:0]  LutTarget;
    logic [D-1:0]  PC;
    logic          Running;
    logic          Done;
    logic          Fault;
    logic [LW-1:0] StackLvl;

    modport master (
        output Start, Stall, Halt, BranchEn, RelMode, CallEn, RetEn,
               BranchIdx, LutTarget,
        input  LutAddr, PC, Running, Done, Fault, StackLvl
    );

    modport slave (
        input  Start, Stall, Halt, BranchEn, RelMode, CallEn, RetEn,
               BranchIdx, LutTarget,
        output LutAddr, PC, Running, Done, Fault, StackLvl
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, return-address stack and the
// IDLE/RUN/DONE/FAULT run lifecycle. Only LutAddr is combinational.
module pc_sequencer #(
    parameter int D     = 10,
    parameter int DEPTH = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    pc_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_e;

    state_e        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic [D-1:0]  stack_q [DEPTH];
    logic [D-1:0]  stack_d [DEPTH];

    logic [D-1:0]  pc_inc;
    logic [LW-1:0] lvl_m1;

    assign pc_inc = pc_q + D'(1);
    assign lvl_m1 = lvl_q - LW'(1);

    // One action per RUN edge; lower-priority requests in the same cycle are dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lvl_d   = lvl_q;
        stack_d = stack_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    lvl_d   = '0;
                end
            end
            S_RUN: begin
                if (bus.Halt) begin
                    state_d = S_DONE;
                end else if (bus.Stall) begin
                    state_d = S_RUN;
                end else if (bus.RetEn) begin
                    if (lvl_q == '0) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d  = stack_q[lvl_m1[AW-1:0]];
                        lvl_d = lvl_m1;
                    end
                end else if (bus.CallEn) begin
                    if (lvl_q == LW'(DEPTH)) begin
                        state_d = S_FAULT;
                    end else begin
                        stack_d[lvl_q[AW-1:0]] = pc_inc;
                        pc_d  = bus.LutTarget;
                        lvl_d = lvl_q + LW'(1);
                    end
                end else if (bus.BranchEn) begin
                    // Relative mode: D-bit add, so a two's-complement target wraps naturally.
                    pc_d = bus.RelMode ? (pc_q + bus.LutTarget) : bus.LutTarget;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            lvl_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lvl_q   <= lvl_d;
        end
    end

    // Stack contents are don't-care after reset; only StackLvl qualifies them.
    always_ff @(posedge Clk) begin
        stack_q <= stack_d;
    end

    assign bus.LutAddr  = bus.BranchIdx;
    assign bus.PC       = pc_q;
    assign bus.StackLvl = lvl_q;
    assign bus.Running  = (state_q == S_RUN);
    assign bus.Done     = (state_q == S_DONE);
    assign bus.Fault    = (state_q == S_FAULT);
endmodule
